// File: rtl/sram_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sram_bus_arbiter                                              |
// | Purpose  : Owns the shared 8-bit external SRAM bus. Arbitrates two       |
// |            req/ack requesters (core c_*, loader l_*) round-robin and     |
// |            sequences address latch, /OE, /WE and the output-latch strobe.|
// | Ports    : clk, reset (async, active-high)                               |
// |            c_req/c_we/c_addr/c_wdata -> c_ack   core requester           |
// |            l_req/l_we/l_addr/l_wdata -> l_ack   loader requester         |
// |            rdata, busy, gnt_id                  status / read data       |
// |            bus_in, bus_out, bus_oe              external data bus        |
// |            mem_latch_clk, mem_oe_n, mem_we_n    SRAM control             |
// |            out_latch_clk                        output latch clock       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module sram_bus_arbiter #(
  parameter logic [7:0] OUT_ADDR  = 8'hFF,
  parameter int         WE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       c_req,
  input  logic       c_we,
  input  logic [7:0] c_addr,
  input  logic [7:0] c_wdata,
  output logic       c_ack,
  input  logic       l_req,
  input  logic       l_we,
  input  logic [7:0] l_addr,
  input  logic [7:0] l_wdata,
  output logic       l_ack,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       gnt_id,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic [7:0] bus_oe,
  output logic       mem_latch_clk,
  output logic       mem_oe_n,
  output logic       mem_we_n,
  output logic       out_latch_clk
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ADDR    = 4'd1,
    S_LATCH   = 4'd2,
    S_RD_OE   = 4'd3,
    S_RD_CAP  = 4'd4,
    S_WR_DATA = 4'd5,
    S_WR_STB  = 4'd6,
    S_WR_HOLD = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  // Strobe counter counts down to zero; load value gives WE_CYCLES cycles.
  localparam logic [1:0] c_STB_LOAD = 2'(WE_CYCLES - 1);

  state_t     r_state;
  logic       r_rr_last;
  logic       r_we;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic [1:0] r_cnt;

  logic       w_req_any;
  logic       w_pick_ld;
  logic       w_sel_we;
  logic [7:0] w_sel_addr;
  logic [7:0] w_sel_wdata;

  // On a tie the requester that did not win last time gets the bus.
  assign w_req_any   = c_req | l_req;
  assign w_pick_ld   = (c_req & l_req) ? ~r_rr_last : l_req;
  assign w_sel_we    = w_pick_ld ? l_we    : c_we;
  assign w_sel_addr  = w_pick_ld ? l_addr  : c_addr;
  assign w_sel_wdata = w_pick_ld ? l_wdata : c_wdata;

  // Outputs are assigned on the transition into a state so that each state's
  // output values are registered and hold for that state's whole cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_rr_last     <= 1'b1;
      r_we          <= 1'b0;
      r_addr        <= 8'h00;
      r_wdata       <= 8'h00;
      r_cnt         <= 2'd0;
      c_ack         <= 1'b0;
      l_ack         <= 1'b0;
      rdata         <= 8'h00;
      busy          <= 1'b0;
      gnt_id        <= 1'b0;
      bus_out       <= 8'h00;
      bus_oe        <= 8'h00;
      mem_latch_clk <= 1'b0;
      mem_oe_n      <= 1'b1;
      mem_we_n      <= 1'b1;
      out_latch_clk <= 1'b0;
    end else begin
      c_ack <= 1'b0;
      l_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_we      <= w_sel_we;
            r_addr    <= w_sel_addr;
            r_wdata   <= w_sel_wdata;
            gnt_id    <= w_pick_ld;
            r_rr_last <= w_pick_ld;
            bus_out   <= w_sel_addr;
            bus_oe    <= 8'hFF;
            busy      <= 1'b1;
            r_state   <= S_ADDR;
          end
        end
        S_ADDR: begin
          mem_latch_clk <= 1'b1;
          r_state       <= S_LATCH;
        end
        S_LATCH: begin
          if (r_we) begin
            bus_out <= r_wdata;
            r_state <= S_WR_DATA;
          end else begin
            // Release the bus in the same cycle the SRAM is enabled to drive it.
            bus_oe   <= 8'h00;
            mem_oe_n <= 1'b0;
            r_state  <= S_RD_OE;
          end
        end
        S_RD_OE: begin
          r_state <= S_RD_CAP;
        end
        S_RD_CAP: begin
          rdata         <= bus_in;
          mem_oe_n      <= 1'b1;
          mem_latch_clk <= 1'b0;
          c_ack         <= ~gnt_id;
          l_ack         <= gnt_id;
          r_state       <= S_DONE;
        end
        S_WR_DATA: begin
          r_cnt <= c_STB_LOAD;
          if (r_addr == OUT_ADDR) begin
            out_latch_clk <= 1'b1;
          end else begin
            mem_we_n <= 1'b0;
          end
          r_state <= S_WR_STB;
        end
        S_WR_STB: begin
          if (r_cnt == 2'd0) begin
            mem_we_n      <= 1'b1;
            out_latch_clk <= 1'b0;
            r_state       <= S_WR_HOLD;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_WR_HOLD: begin
          bus_oe        <= 8'h00;
          mem_latch_clk <= 1'b0;
          c_ack         <= ~gnt_id;
          l_ack         <= gnt_id;
          r_state       <= S_DONE;
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
